// File: rtl/alu_pkg.sv
// Shared types and helpers for the pipelined execute-stage ALU.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0010,
    OP_OR  = 4'b0011,
    OP_XOR = 4'b0100,
    OP_SHL = 4'b0101,
    OP_SHR = 4'b0110,
    OP_SAR = 4'b0111,
    OP_MUL = 4'b1000
  } op_t;

  typedef enum logic [1:0] {
    SZ_8  = 2'b00,
    SZ_16 = 2'b01,
    SZ_32 = 2'b10,
    SZ_64 = 2'b11
  } sz_t;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  // Bit positions inside the {N,Z,C,V} flag vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Operand width in bits for a size code; sizes wider than the datapath clamp to it.
  function automatic int unsigned size_bits(sz_t sz, int unsigned xlen);
    int unsigned bits;
    bits = 32'd8 << sz;
    return (bits > xlen) ? xlen : bits;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned multiplier retiring MUL_STEP multiplier bits per cycle.
// Latency: XLEN/MUL_STEP cycles after start; done is high on the final step.
// Backpressure: none; the caller only starts it when the result register can take the product.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int MUL_STEP = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_src1,
  input  logic [XLEN-1:0] i_src2,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_product
);

  localparam int STEPS = XLEN / MUL_STEP;
  localparam int CW    = $clog2(STEPS + 1);

  logic [XLEN-1:0] src1_q, src1_d;
  logic [XLEN-1:0] src2_q, src2_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic [XLEN-1:0] partial;
  logic [XLEN-1:0] acc_next;
  logic            done;

  // One partial product per cycle; the final sum is presented combinationally on the last step.
  always_comb begin
    partial  = src1_q * XLEN'(src2_q[MUL_STEP-1:0]);
    acc_next = acc_q + partial;
    done     = busy_q && (cnt_q == CW'(1));
    src1_d   = src1_q;
    src2_d   = src2_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (i_start) begin
      src1_d = i_src1;
      src2_d = i_src2;
      acc_d  = '0;
      cnt_d  = CW'(STEPS);
      busy_d = 1'b1;
    end else if (busy_q) begin
      acc_d  = acc_next;
      src1_d = src1_q << MUL_STEP;
      src2_d = src2_q >> MUL_STEP;
      cnt_d  = cnt_q - CW'(1);
      if (done) begin
        busy_d = 1'b0;
      end
    end
  end

  // Operand, accumulator and step-counter registers; reset drops any product in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      src1_q <= '0;
      src2_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      src1_q <= src1_d;
      src2_q <= src2_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign o_busy    = busy_q;
  assign o_done    = done;
  assign o_product = acc_next;

endmodule

// File: rtl/alu_pipe.sv
// Registered execute-stage ALU: add/sub/logic/shift/mul at 8..XLEN bits with NZCV flags.
// Latency: 1 cycle for single-cycle ops, XLEN/MUL_STEP+1 cycles for MUL.
// Backpressure: result held while i_ready is low; o_ready drops while full-and-stalled or multiplying.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int MUL_STEP = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [3:0]      i_op,
  input  logic [1:0]      i_sz,
  input  logic [XLEN-1:0] i_src1,
  input  logic [XLEN-1:0] i_src2,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_dest,
  output logic [3:0]      o_flags
);

  localparam int SW = $clog2(XLEN) + 1;
  localparam int AW = $clog2(XLEN);

  op_t             op;
  logic            accept;
  logic            mul_start;
  logic            mul_busy;
  logic            mul_done;
  logic [XLEN-1:0] mul_product;

  logic [SW-1:0]   sbits;
  logic [XLEN-1:0] mask, msb, a, b, a_sx, sar, sc_res;
  logic [XLEN:0]   sum, diff;
  logic [AW-1:0]   amt;
  logic            sa, sb, sr, sc_c, sc_v, sc_listed;
  logic [3:0]      sc_flags;

  logic [XLEN-1:0] mul_res, mul_msb;
  logic [3:0]      mul_flags;

  state_t          state_q, state_d;
  logic            vld_q, vld_d;
  logic [XLEN-1:0] dest_q, dest_d;
  logic [3:0]      flags_q, flags_d;
  logic [XLEN-1:0] mul_mask_q, mul_mask_d;

  assign op        = op_t'(i_op);
  assign o_ready   = !i_rst && (state_q == IDLE) && !mul_busy && (!vld_q || i_ready);
  assign accept    = i_valid && o_ready;
  assign mul_start = accept && (op == OP_MUL);

  // Single-cycle datapath: truncate operands to the selected size, compute, derive flags.
  always_comb begin
    sbits = SW'(size_bits(sz_t'(i_sz), XLEN));
    mask  = ~({XLEN{1'b1}} << sbits);
    msb   = mask ^ (mask >> 1);
    a     = i_src1 & mask;
    b     = i_src2 & mask;
    sa    = |(a & msb);
    sb    = |(b & msb);
    sum   = {1'b0, a} + {1'b0, b};
    diff  = {1'b0, a} - {1'b0, b};
    amt   = i_src2[AW-1:0] & AW'(sbits - SW'(1));
    // Sign-extend from bit S-1 so the arithmetic shift pulls in the size's own sign bit.
    a_sx  = a | ({XLEN{sa}} & ~mask);
    sar   = $signed(a_sx) >>> amt;
    sc_res    = '0;
    sc_c      = 1'b0;
    sc_v      = 1'b0;
    sc_listed = 1'b1;
    case (op)
      OP_ADD: begin
        sc_res = sum[XLEN-1:0] & mask;
        sc_c   = |(sum & ({1'b0, mask} + {{XLEN{1'b0}}, 1'b1}));
      end
      OP_SUB: begin
        sc_res = diff[XLEN-1:0] & mask;
        sc_c   = (a < b);
      end
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_SHL:  sc_res = (a << amt) & mask;
      OP_SHR:  sc_res = a >> amt;
      OP_SAR:  sc_res = sar & mask;
      OP_MUL:  sc_res = '0;
      default: sc_listed = 1'b0;
    endcase
    sr = |(sc_res & msb);
    if (op == OP_ADD) begin
      sc_v = (sa == sb) && (sr != sa);
    end else if (op == OP_SUB) begin
      sc_v = (sa != sb) && (sr != sa);
    end
    sc_flags = '0;
    if (sc_listed) begin
      sc_flags[FLAG_N] = sr;
      sc_flags[FLAG_Z] = (sc_res == '0);
      sc_flags[FLAG_C] = sc_c;
      sc_flags[FLAG_V] = sc_v;
    end
  end

  alu_mul_iter #(
    .XLEN     (XLEN),
    .MUL_STEP (MUL_STEP)
  ) u_mul (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (mul_start),
    .i_src1    (a),
    .i_src2    (b),
    .o_busy    (mul_busy),
    .o_done    (mul_done),
    .o_product (mul_product)
  );

  // Product is trimmed to the size latched at issue; only N and Z can be set by MUL.
  always_comb begin
    mul_res   = mul_product & mul_mask_q;
    mul_msb   = mul_mask_q ^ (mul_mask_q >> 1);
    mul_flags = '0;
    mul_flags[FLAG_N] = |(mul_res & mul_msb);
    mul_flags[FLAG_Z] = (mul_res == '0);
  end

  // Sequencing and output register: a handoff empties the slot unless a new result lands the same edge.
  always_comb begin
    state_d    = state_q;
    vld_d      = vld_q && !i_ready;
    dest_d     = dest_q;
    flags_d    = flags_q;
    mul_mask_d = mul_mask_q;
    case (state_q)
      IDLE: begin
        if (mul_start) begin
          state_d    = MUL;
          mul_mask_d = mask;
        end else if (accept) begin
          vld_d   = 1'b1;
          dest_d  = sc_res;
          flags_d = sc_flags;
        end
      end
      MUL: begin
        if (mul_done) begin
          state_d = IDLE;
          vld_d   = 1'b1;
          dest_d  = mul_res;
          flags_d = mul_flags;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset clears everything at once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      vld_q      <= 1'b0;
      dest_q     <= '0;
      flags_q    <= '0;
      mul_mask_q <= '0;
    end else begin
      state_q    <= state_d;
      vld_q      <= vld_d;
      dest_q     <= dest_d;
      flags_q    <= flags_d;
      mul_mask_q <= mul_mask_d;
    end
  end

  assign o_valid = vld_q;
  assign o_dest  = dest_q;
  assign o_flags = flags_q;

endmodule
